// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves one vector register to or from a word-wide
// data memory as NUM_ELEM consecutive element accesses, holding busy meanwhile.
module vec_mem_seq #(
    parameter int NUM_ELEM = 16,
    parameter int ELEM_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         is_store,
    input  logic [15:0]                  base_addr,
    input  logic [NUM_ELEM*ELEM_W-1:0]   store_data,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_ELEM*ELEM_W-1:0]   load_data,
    output logic [15:0]                  mem_addr,
    output logic                         mem_re,
    output logic                         mem_we,
    output logic [ELEM_W-1:0]            mem_wdata,
    input  logic [ELEM_W-1:0]            mem_rdata,
    input  logic                         mem_rdy
);

    localparam int VW    = NUM_ELEM * ELEM_W;
    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             store_q;
    logic [VW-1:0]    wbuf;
    logic [VW-1:0]    wbuf_shift;
    logic             advance;
    logic             last;

    assign advance    = (state == XFER) && mem_rdy;
    assign last       = (idx == LAST_IDX);
    assign wbuf_shift = wbuf >> ELEM_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                busy   = 1'b1;
                mem_re = !store_q;
                mem_we = store_q;
                if (mem_rdy && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // mem_addr tracks base+idx incrementally; the store buffer shifts so the
    // next element's write data is always in its lowest lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            store_q   <= 1'b0;
            wbuf      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_data <= '0;
        end else if (state == IDLE && start) begin
            idx      <= '0;
            store_q  <= is_store;
            mem_addr <= base_addr;
            if (is_store) begin
                wbuf      <= store_data;
                mem_wdata <= store_data[ELEM_W-1:0];
            end
        end else if (advance) begin
            if (!store_q) begin
                load_data[idx*ELEM_W +: ELEM_W] <= mem_rdata;
            end
            if (!last) begin
                idx      <= idx + 1'b1;
                mem_addr <= mem_addr + 16'd1;
                if (store_q) begin
                    wbuf      <= wbuf_shift;
                    mem_wdata <= wbuf_shift[ELEM_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Self-checking bench for vec_mem_seq: a word-addressed memory model with
// optional stalls answers requests, and each scenario checks against expectations.
module tb_vec_mem_seq;

    localparam int NE = 16;
    localparam int EW = 16;
    localparam int VW = NE * EW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          is_store = 1'b0;
    logic [15:0]   base_addr = '0;
    logic [VW-1:0] store_data = '0;
    logic          busy;
    logic          done;
    logic [VW-1:0] load_data;
    logic [15:0]   mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [EW-1:0] mem_wdata;
    logic [EW-1:0] mem_rdata = '0;
    logic          mem_rdy = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int stall_viol = 0;
    bit stall_en = 1'b0;
    int elem_cnt = 0;
    int stall_cnt = 0;
    bit prev_stalled = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;
    logic        prev_re = 1'b0;
    logic        prev_we = 1'b0;

    logic [15:0] mem_model [0:65535];
    logic [15:0] acc_addr[$];
    logic [15:0] acc_data[$];
    bit          acc_we[$];

    vec_mem_seq #(.NUM_ELEM(NE), .ELEM_W(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rdy    (mem_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory model: decides mem_rdy for the coming edge, logs every accepted
    // access, and flags any request change while the previous cycle was stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            elem_cnt     = 0;
            stall_cnt    = 0;
            prev_stalled = 1'b0;
            mem_rdy      = 1'($urandom_range(0, 1));
        end else begin
            if (prev_stalled && (mem_addr !== prev_addr || mem_re !== prev_re ||
                                 mem_we !== prev_we || (prev_we && mem_wdata !== prev_wdata)))
                stall_viol++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
            end
            if (mem_re === 1'b1 || mem_we === 1'b1) begin
                if (stall_en && elem_cnt[0] && stall_cnt < 2) begin
                    mem_rdy = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_rdy = 1'b1;
                end
                if (mem_rdy) begin
                    acc_addr.push_back(mem_addr);
                    acc_we.push_back(mem_we);
                    acc_data.push_back(mem_we ? mem_wdata : mem_model[mem_addr]);
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    elem_cnt++;
                    stall_cnt = 0;
                end
                prev_stalled = !mem_rdy;
                prev_addr    = mem_addr;
                prev_wdata   = mem_wdata;
                prev_re      = mem_re;
                prev_we      = mem_we;
            end else begin
                mem_rdy      = 1'($urandom_range(0, 1));
                elem_cnt     = 0;
                stall_cnt    = 0;
                prev_stalled = 1'b0;
            end
        end
        mem_rdata = mem_model[mem_addr];
    end

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_xfer(input bit st, input logic [15:0] base,
                              input logic [VW-1:0] data, input bit stalls);
        @(negedge clk); #1;
        acc_addr.delete();
        acc_data.delete();
        acc_we.delete();
        done_cnt   = 0;
        stall_viol = 0;
        stall_en   = stalls;
        start_cyc  = cyc;
        start      = 1'b1;
        is_store   = st;
        base_addr  = base;
        store_data = data;
        @(posedge clk); #1;
        start      = 1'b0;
        is_store   = 1'($urandom_range(0, 1));
        base_addr  = 16'($urandom);
        store_data = rand_vec();
    endtask

    task automatic wait_done(input int budget, output bit timeout);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        timeout = (done_cnt == 0);
    endtask

    task automatic test_reset();
        #1;
        rst_n      = 1'b0;
        start      = 1'($urandom_range(0, 1));
        is_store   = 1'($urandom_range(0, 1));
        base_addr  = 16'($urandom);
        store_data = rand_vec();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        n_vec++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req: got re=%b we=%b want 0 0", mem_re, mem_we); end
        n_vec++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_err++; $display("[TB] FAIL reset_addr_wdata: got %h %h want 0 0", mem_addr, mem_wdata); end
        n_vec++; if (load_data !== '0) begin n_err++; $display("[TB] FAIL reset_load_data: got %h want 0", load_data); end
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_idle c%0d: got busy=%b done=%b want 0 0", c, busy, done); end
        end
    endtask

    task automatic test_store();
        logic [VW-1:0] v;
        logic [VW-1:0] ld_before;
        bit to;
        for (int i = 0; i < NE; i++) v[i*EW +: EW] = 16'(16'h1000 + i);
        ld_before = load_data;
        start_xfer(1'b1, 16'h0100, v, 1'b0);
        wait_done(100, to);
        n_vec++; if (to) begin n_err++; $display("[TB] FAIL store_timeout: got no done want done"); end
        n_vec++; if (done_cyc != 17) begin n_err++; $display("[TB] FAIL store_done_cycle: got %0d want 17", done_cyc); end
        repeat (3) @(negedge clk); #1;
        n_vec++; if (done_cnt != 1) begin n_err++; $display("[TB] FAIL store_done_count: got %0d want 1", done_cnt); end
        n_vec++; if (acc_addr.size() != NE) begin n_err++; $display("[TB] FAIL store_access_count: got %0d want %0d", acc_addr.size(), NE); end
        for (int i = 0; i < NE && i < acc_addr.size(); i++) begin
            n_vec++;
            if (acc_we[i] !== 1'b1 || acc_addr[i] !== 16'(16'h0100 + i) || acc_data[i] !== 16'(16'h1000 + i)) begin
                n_err++;
                $display("[TB] FAIL store_elem%0d: got we=%b addr=%h data=%h want 1 %h %h", i, acc_we[i], acc_addr[i], acc_data[i], 16'(16'h0100 + i), 16'(16'h1000 + i));
            end
        end
        n_vec++; if (load_data !== ld_before) begin n_err++; $display("[TB] FAIL store_keeps_load_data: got %h want %h", load_data, ld_before); end
    endtask

    task automatic test_load_wrap();
        bit to;
        logic [15:0] a;
        for (int i = 0; i < NE; i++) begin
            a = 16'(16'hFFF8 + i);
            mem_model[a] = 16'(16'hA000 + a);
        end
        start_xfer(1'b0, 16'hFFF8, '0, 1'b1);
        wait_done(200, to);
        n_vec++; if (to) begin n_err++; $display("[TB] FAIL load_wrap_timeout: got no done want done"); end
        n_vec++; if (done_cyc != 33) begin n_err++; $display("[TB] FAIL load_wrap_done_cycle: got %0d want 33", done_cyc); end
        n_vec++; if (stall_viol != 0) begin n_err++; $display("[TB] FAIL load_wrap_stall_stable: got %0d changes want 0", stall_viol); end
        for (int i = 0; i < NE; i++) begin
            n_vec++;
            if (load_data[i*EW +: EW] !== 16'(16'hA000 + 16'(16'hFFF8 + i))) begin
                n_err++;
                $display("[TB] FAIL load_wrap_lane%0d: got %h want %h", i, load_data[i*EW +: EW], 16'(16'hA000 + 16'(16'hFFF8 + i)));
            end
        end
        for (int i = 0; i < NE && i < acc_addr.size(); i++) begin
            n_vec++;
            if (acc_we[i] !== 1'b0 || acc_addr[i] !== 16'(16'hFFF8 + i)) begin
                n_err++;
                $display("[TB] FAIL load_wrap_addr%0d: got we=%b addr=%h want 0 %h", i, acc_we[i], acc_addr[i], 16'(16'hFFF8 + i));
            end
        end
        repeat (2) @(negedge clk); #1;
        n_vec++; if (mem_addr !== 16'h0007 || mem_re !== 1'b0) begin n_err++; $display("[TB] FAIL load_wrap_hold: got addr=%h re=%b want 0007 0", mem_addr, mem_re); end
    endtask

    task automatic test_ignored_start();
        bit to;
        logic [VW-1:0] v;
        logic [15:0] base;
        v = rand_vec();
        base = 16'h3000;
        start_xfer(1'b1, base, v, 1'b0);
        repeat (5) @(negedge clk); #1;
        start = 1'b1; base_addr = 16'h0200; is_store = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(100, to);
        n_vec++; if (to) begin n_err++; $display("[TB] FAIL ignored_start_timeout: got no done want done"); end
        start = 1'b1; base_addr = 16'h0200; is_store = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk); #1;
        n_vec++; if (done_cnt != 1) begin n_err++; $display("[TB] FAIL ignored_start_done_count: got %0d want 1", done_cnt); end
        n_vec++; if (acc_addr.size() != NE) begin n_err++; $display("[TB] FAIL ignored_start_access_count: got %0d want %0d", acc_addr.size(), NE); end
        for (int i = 0; i < NE && i < acc_addr.size(); i++) begin
            n_vec++;
            if (acc_addr[i] !== 16'(base + i) || acc_data[i] !== v[i*EW +: EW]) begin
                n_err++;
                $display("[TB] FAIL ignored_start_elem%0d: got addr=%h data=%h want %h %h", i, acc_addr[i], acc_data[i], 16'(base + i), v[i*EW +: EW]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        int n = 0;
        logic [15:0] base;
        logic [VW-1:0] exp_v;
        base = 16'($urandom);
        start_xfer(1'b0, base, '0, 1'b0);
        while (acc_addr.size() < 8 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        n_vec++; if (acc_addr.size() != 8) begin n_err++; $display("[TB] FAIL mid_reset_reach_elem7: got %0d accesses want 8", acc_addr.size()); end
        n_vec++; if (mem_re !== 1'b1 || mem_addr !== 16'(base + 7)) begin n_err++; $display("[TB] FAIL mid_reset_elem7_req: got re=%b addr=%h want 1 %h", mem_re, mem_addr, 16'(base + 7)); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (mem_re !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_async: got re=%b busy=%b want 0 0", mem_re, busy); end
        n_vec++; if (load_data !== '0 || mem_addr !== 16'h0) begin n_err++; $display("[TB] FAIL mid_reset_clear: got load_data=%h addr=%h want 0 0", load_data, mem_addr); end
        @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0 || mem_re !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_not_resumed: got busy=%b re=%b want 0 0", busy, mem_re); end
        base = 16'($urandom);
        for (int i = 0; i < NE; i++) exp_v[i*EW +: EW] = mem_model[16'(base + i)];
        start_xfer(1'b0, base, '0, 1'b0);
        wait_done(100, to);
        n_vec++; if (to || done_cyc != 17) begin n_err++; $display("[TB] FAIL mid_reset_reload_done: got timeout=%b cycle=%0d want 0 17", to, done_cyc); end
        n_vec++; if (load_data !== exp_v) begin n_err++; $display("[TB] FAIL mid_reset_reload_data: got %h want %h", load_data, exp_v); end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [15:0] base;
        logic [VW-1:0] v;
        base = 16'($urandom);
        v = rand_vec();
        start_xfer(1'b1, base, v, 1'b0);
        wait_done(100, to);
        n_vec++; if (to || done_cyc != 17) begin n_err++; $display("[TB] FAIL b2b_store_done: got timeout=%b cycle=%0d want 0 17", to, done_cyc); end
        start_xfer(1'b0, base, '0, 1'b0);
        n_vec++; if (busy !== 1'b1 || mem_re !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_load_accepted: got busy=%b re=%b want 1 1", busy, mem_re); end
        wait_done(100, to);
        n_vec++; if (to || done_cyc != 17) begin n_err++; $display("[TB] FAIL b2b_load_done: got timeout=%b cycle=%0d want 0 17", to, done_cyc); end
        n_vec++; if (load_data !== v) begin n_err++; $display("[TB] FAIL b2b_readback: got %h want %h", load_data, v); end
    endtask

    task automatic test_random();
        bit to;
        bit st;
        bit stalls;
        logic [15:0] base;
        logic [VW-1:0] v;
        logic [VW-1:0] exp_v;
        for (int t = 0; t < 6; t++) begin
            st     = 1'($urandom_range(0, 1));
            stalls = 1'($urandom_range(0, 1));
            base   = 16'($urandom);
            v      = rand_vec();
            exp_v  = load_data;
            if (!st) for (int i = 0; i < NE; i++) exp_v[i*EW +: EW] = mem_model[16'(base + i)];
            start_xfer(st, base, v, stalls);
            wait_done(200, to);
            n_vec++;
            if (to || done_cyc != (stalls ? 33 : 17)) begin
                n_err++;
                $display("[TB] FAIL random%0d_done: got timeout=%b cycle=%0d want 0 %0d", t, to, done_cyc, stalls ? 33 : 17);
            end
            n_vec++; if (stall_viol != 0) begin n_err++; $display("[TB] FAIL random%0d_stall_stable: got %0d changes want 0", t, stall_viol); end
            n_vec++; if (load_data !== exp_v) begin n_err++; $display("[TB] FAIL random%0d_load_data: got %h want %h", t, load_data, exp_v); end
            if (st) begin
                for (int i = 0; i < NE && i < acc_addr.size(); i++) begin
                    n_vec++;
                    if (acc_we[i] !== 1'b1 || acc_addr[i] !== 16'(base + i) || acc_data[i] !== v[i*EW +: EW]) begin
                        n_err++;
                        $display("[TB] FAIL random%0d_store_elem%0d: got we=%b addr=%h data=%h want 1 %h %h", t, i, acc_we[i], acc_addr[i], acc_data[i], 16'(base + i), v[i*EW +: EW]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem_model[a] = 16'($urandom);
        test_reset();
        test_store();
        test_load_wrap();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
